// File: rtl/counter_cmd_seq.sv
// Command front-end for the loadable up/down counter: takes LOAD/RUN_UP/RUN_DOWN/NOP
// over valid/ready and sequences the counter's ce/load_n/up_down/data_load controls.
module counter_cmd_seq #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned STEP_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [WIDTH-1:0]  cmd_data,
    input  logic [STEP_W-1:0] cmd_steps,
    input  logic              pause,
    input  logic [WIDTH-1:0]  count_in,
    output logic              ce,
    output logic              load_n,
    output logic              up_down,
    output logic [WIDTH-1:0]  data_load,
    output logic              busy,
    output logic              done,
    output logic              wrap
);

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_LOAD = 2'b01;
    localparam logic [1:0] OP_UP   = 2'b10;
    localparam logic [1:0] OP_DOWN = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [STEP_W-1:0] remaining;
    logic              accept;
    logic              run_op;

    assign accept = cmd_valid && cmd_ready;
    assign run_op = (cmd_op == OP_UP) || (cmd_op == OP_DOWN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (cmd_op == OP_LOAD) begin
                        state_nxt = S_LOAD;
                    end else if (run_op && (cmd_steps != '0)) begin
                        state_nxt = S_RUN;
                    end else begin
                        state_nxt = S_DONE;
                    end
                end
            end
            S_LOAD: state_nxt = S_DONE;
            S_RUN: begin
                if (!pause && (remaining == STEP_W'(1))) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Command fields are captured only at accept; up_down/data_load persist between commands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            remaining <= '0;
            data_load <= '0;
            up_down   <= 1'b0;
        end else if (accept) begin
            if (cmd_op == OP_LOAD) begin
                data_load <= cmd_data;
            end
            if (run_op && (cmd_steps != '0)) begin
                remaining <= cmd_steps;
                up_down   <= ~cmd_op[0];
            end
        end else if ((state == S_RUN) && !pause) begin
            remaining <= remaining - STEP_W'(1);
        end
    end

    always_comb begin
        cmd_ready = (state == S_IDLE) && !rst;
        ce        = (state == S_RUN) && !pause;
        load_n    = (state != S_LOAD);
        busy      = (state != S_IDLE);
        done      = (state == S_DONE);
        wrap      = ce && ((up_down && (count_in == '1)) || (!up_down && (count_in == '0)));
    end

    logic unused_nop;
    assign unused_nop = (OP_NOP == 2'b00);

endmodule

// File: tb/tb_counter_cmd_seq.sv
// Bench for counter_cmd_seq: drives commands into the sequencer, closes the loop through a
// simple counter, and checks directed vectors plus random commands against a step-level model.
module tb_counter_cmd_seq;

    localparam int W  = 4;
    localparam int SW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_op = 2'b00;
    logic [W-1:0]  cmd_data = '0;
    logic [SW-1:0] cmd_steps = '0;
    logic          pause = 1'b0;
    logic [W-1:0]  count_in;
    logic          ce, load_n, up_down, busy, done, wrap;
    logic [W-1:0]  data_load;

    logic [W-1:0]  cnt = '0;

    int checks = 0;
    int errors = 0;

    counter_cmd_seq #(.WIDTH(W), .STEP_W(SW)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_steps(cmd_steps), .pause(pause),
        .count_in(count_in), .ce(ce), .load_n(load_n), .up_down(up_down),
        .data_load(data_load), .busy(busy), .done(done), .wrap(wrap)
    );

    always #5 clk = ~clk;

    // Downstream counter, not affected by the sequencer's reset.
    assign count_in = cnt;
    always @(posedge clk) begin
        if (!load_n) cnt <= data_load;
        else if (ce) cnt <= up_down ? cnt + 1'b1 : cnt - 1'b1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [3:0]  data;
        logic [7:0]  steps;
        logic [31:0] pmask;
        int          lat;
        int          ces;
        int          wraps;
        logic [3:0]  fin;
    } vec_t;

    // Expected outcome of one command from its fields, the pause pattern and the start count.
    function automatic void model(input logic [1:0] op, input logic [3:0] data,
                                  input logic [7:0] steps, input logic [31:0] pmask,
                                  input int start, output int lat, output int ces,
                                  output int wraps, output int loads, output int fin);
        int cur, n, k;
        bit up, p;
        lat = 1; ces = 0; wraps = 0; loads = 0; fin = start;
        if (op == 2'b01) begin
            lat = 2; loads = 1; fin = int'(data);
        end else if (op[1] && steps != 0) begin
            up = !op[0]; cur = start; n = 0; k = 0;
            while (n < int'(steps)) begin
                k++;
                p = (k <= 32) ? pmask[(k - 1) % 32] : 1'b0;
                if (!p) begin
                    if (up && cur == 15) wraps++;
                    if (!up && cur == 0) wraps++;
                    cur = up ? (cur + 1) % 16 : (cur + 15) % 16;
                    n++;
                end
            end
            lat = k + 1; ces = int'(steps); fin = cur;
        end
    endfunction

    // Called shortly after a falling edge; returns observed behaviour of one command.
    task automatic run_cmd(input logic [1:0] op, input logic [3:0] data, input logic [7:0] steps,
                           input logic [31:0] pmask, output int lat, output int ces,
                           output int wraps, output int loads, output int fin);
        int w, hs_bad;
        lat = -1; ces = 0; wraps = 0; loads = 0; hs_bad = 0; w = 0;
        while (!cmd_ready && w < 10) begin
            @(negedge clk); #1; w++;
        end
        chk("ready_before_cmd", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1; cmd_op = op; cmd_data = data; cmd_steps = steps; pause = 1'b0;
        @(posedge clk); #1;
        // keep valid high with junk fields while busy: must be ignored
        cmd_op = 2'($urandom); cmd_data = 4'($urandom); cmd_steps = 8'($urandom);
        for (int k = 1; k <= 400; k++) begin
            @(negedge clk);
            pause = (k <= 32) ? pmask[(k - 1) % 32] : 1'b0;
            #1;
            if (ce) ces++;
            if (wrap) wraps++;
            if (!load_n) loads++;
            if (cmd_ready || !busy) hs_bad++;
            if (done) begin
                lat = k;
                break;
            end
        end
        cmd_valid = 1'b0;
        chk("busy_ready_during_cmd", 32'(hs_bad), 32'd0);
        @(negedge clk);
        pause = 1'b0;
        #1;
        chk("done_single_pulse", 32'(done), 32'd0);
        chk("ready_after_done", 32'(cmd_ready), 32'd1);
        fin = int'(cnt);
    endtask

    vec_t vecs[8];

    initial begin
        int lat, ces, wraps, loads, fin;
        int elat, eces, ewraps, eloads, efin, start;
        logic [3:0] exp_dl;
        logic       exp_ud;
        logic [1:0] op;
        logic [3:0] data;
        logic [7:0] steps;
        logic [31:0] pmask;
        int bad_done;

        vecs[0] = '{2'b01, 4'hA, 8'd0,  32'h0, 2, 0, 0, 4'hA};
        vecs[1] = '{2'b10, 4'h0, 8'd3,  32'h0, 4, 3, 0, 4'hD};
        vecs[2] = '{2'b01, 4'hE, 8'd0,  32'h0, 2, 0, 0, 4'hE};
        vecs[3] = '{2'b10, 4'h0, 8'd3,  32'h0, 4, 3, 1, 4'h1};
        vecs[4] = '{2'b01, 4'h9, 8'd0,  32'h0, 2, 0, 0, 4'h9};
        vecs[5] = '{2'b11, 4'h0, 8'd5,  32'hC, 8, 5, 0, 4'h4};
        vecs[6] = '{2'b10, 4'h0, 8'd0,  32'h0, 1, 0, 0, 4'h4};
        vecs[7] = '{2'b00, 4'h7, 8'd9,  32'h0, 1, 0, 0, 4'h4};

        // reset asserted mid-cycle
        #7 rst = 1'b1;
        #1;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_ce", 32'(ce), 32'd0);
        chk("rst_load_n", 32'(load_n), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_wrap", 32'(wrap), 32'd0);
        chk("rst_data_load", 32'(data_load), 32'd0);
        chk("rst_up_down", 32'(up_down), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", 32'(cmd_ready), 32'd1);
        chk("busy_after_rst", 32'(busy), 32'd0);

        for (int i = 0; i < 8; i++) begin
            run_cmd(vecs[i].op, vecs[i].data, vecs[i].steps, vecs[i].pmask, lat, ces, wraps, loads, fin);
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            chk($sformatf("vec%0d_ce_count", i), 32'(ces), 32'(vecs[i].ces));
            chk($sformatf("vec%0d_wraps", i), 32'(wraps), 32'(vecs[i].wraps));
            chk($sformatf("vec%0d_loads", i), 32'(loads), (vecs[i].op == 2'b01) ? 32'd1 : 32'd0);
            chk($sformatf("vec%0d_count", i), 32'(fin), 32'(vecs[i].fin));
        end
        chk("vec_up_down_held", 32'(up_down), 32'd0);
        chk("vec_data_load_held", 32'(data_load), 32'h9);

        exp_dl = 4'h9; exp_ud = 1'b0;
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom); data = 4'($urandom);
            steps = 8'($urandom_range(0, 20));
            pmask = $urandom & $urandom;
            start = int'(cnt);
            model(op, data, steps, pmask, start, elat, eces, ewraps, eloads, efin);
            if (op == 2'b01) exp_dl = data;
            if (op[1] && steps != 0) exp_ud = !op[0];
            run_cmd(op, data, steps, pmask, lat, ces, wraps, loads, fin);
            chk($sformatf("rnd%0d_latency", i), 32'(lat), 32'(elat));
            chk($sformatf("rnd%0d_ce_count", i), 32'(ces), 32'(eces));
            chk($sformatf("rnd%0d_wraps", i), 32'(wraps), 32'(ewraps));
            chk($sformatf("rnd%0d_loads", i), 32'(loads), 32'(eloads));
            chk($sformatf("rnd%0d_count", i), 32'(fin), 32'(efin));
            chk($sformatf("rnd%0d_data_load", i), 32'(data_load), 32'(exp_dl));
            chk($sformatf("rnd%0d_up_down", i), 32'(up_down), 32'(exp_ud));
        end

        // RUN_UP 10 aborted by reset after three steps
        start = int'(cnt);
        chk("abort_ready", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1; cmd_op = 2'b10; cmd_steps = 8'd10; pause = 1'b0;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("abort_ce_before_rst", 32'(ce), 32'd1);
        rst = 1'b1;
        #1;
        chk("abort_ce_async", 32'(ce), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_load_n", 32'(load_n), 32'd1);
        chk("abort_ready_in_rst", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_ready_after", 32'(cmd_ready), 32'd1);
        chk("abort_up_down_reset", 32'(up_down), 32'd0);
        chk("abort_data_load_reset", 32'(data_load), 32'd0);
        bad_done = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); #1;
            if (done || busy || ce) bad_done++;
        end
        chk("abort_no_done", 32'(bad_done), 32'd0);
        chk("abort_count", 32'(cnt), 32'((start + 3) % 16));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
